// File: rtl/mem_pkg.sv
// mem_pkg: funct3 width codes, stage state encoding and the access legality rule
// shared by the memory-access stage and its bench.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [0:0] S_PASS = 1'b0;
    localparam logic [0:0] S_RMW  = 1'b1;

    // True when a memory op cannot be issued: bad width code, misaligned, or ambiguous class.
    function automatic logic access_fault(input logic ld, input logic st, input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        mis = (f3[1:0] == 2'b10 && off != 2'b00) || (f3[1:0] == 2'b01 && off[0]);
        return (ld && st)
            || (st && !(f3 inside {F3_B, F3_H, F3_W}))
            || (ld && !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
            || ((ld || st) && mis);
    endfunction

endpackage

// File: rtl/store_merge.sv
// store_merge: little-endian lane merge of store data into an old memory word.
module store_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        if (funct3[1])
            merged = data;
        else if (funct3[0])
            merged[{offset[1], 4'b0000} +: 16] = data[15:0];
        else
            merged[{offset, 3'b000} +: 8] = data[7:0];
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: registers ops toward data memory; sub-word stores become a
// read (S_RMW) followed by a merged full-word write.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [2:0]  ex_funct3,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic        mem_valid,
    output logic [4:0]  mem_rd,
    output logic [2:0]  mem_ld_funct3,
    output logic [1:0]  mem_ld_off,
    output logic        mem_fault
);

    logic [0:0]  state;
    logic [31:0] rmw_data;
    logic [1:0]  rmw_off;
    logic [2:0]  rmw_f3;
    logic [31:0] merged;
    logic        accept, is_mem, is_st, fault, sub_word;

    assign ex_ready = RST_X && state == S_PASS;
    assign accept   = ex_valid && ex_ready && !flush;
    assign is_mem   = ex_is_load || ex_is_store;
    assign is_st    = ex_is_store && !ex_is_load;
    assign fault    = CHECK_ALIGN && access_fault(ex_is_load, ex_is_store, ex_funct3, ex_addr[1:0]);
    assign sub_word = is_st && !ex_funct3[1];

    store_merge u_merge (
        .old_word(mem_rdata),
        .data    (rmw_data),
        .offset  (rmw_off),
        .funct3  (rmw_f3),
        .merged  (merged)
    );

    // Control outputs default to a bubble each cycle; data fields hold until the next accept.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state         <= S_PASS;
            mem_addr      <= '0;
            mem_wd        <= '0;
            mem_we        <= 1'b0;
            mem_valid     <= 1'b0;
            mem_rd        <= '0;
            mem_ld_funct3 <= '0;
            mem_ld_off    <= '0;
            mem_fault     <= 1'b0;
            rmw_data      <= '0;
            rmw_off       <= '0;
            rmw_f3        <= '0;
        end else begin
            mem_we    <= 1'b0;
            mem_valid <= 1'b0;
            mem_fault <= 1'b0;
            if (state == S_RMW) begin
                state <= S_PASS;
                if (!flush) begin
                    mem_wd    <= merged;
                    mem_we    <= 1'b1;
                    mem_valid <= 1'b1;
                end
            end else if (accept) begin
                mem_addr      <= is_mem ? {ex_addr[31:2], 2'b00} : ex_addr;
                mem_wd        <= ex_wdata;
                mem_rd        <= is_st ? 5'd0 : ex_rd;
                mem_ld_funct3 <= ex_funct3;
                mem_ld_off    <= ex_addr[1:0];
                rmw_data      <= ex_wdata;
                rmw_off       <= ex_addr[1:0];
                rmw_f3        <= ex_funct3;
                if (fault)
                    mem_fault <= 1'b1;
                else if (sub_word)
                    state <= S_RMW;
                else begin
                    mem_valid <= 1'b1;
                    mem_we    <= is_st;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed vector table, hand-written multi-cycle corners and a
// randomized run against a behavioural model of the stage.
module tb_mem_access_stage;

    logic        CLK = 1'b0, RST_X = 1'b0;
    logic        ex_valid = 1'b0, ex_is_load = 1'b0, ex_is_store = 1'b0, flush = 1'b0;
    logic [31:0] ex_addr = '0, ex_wdata = '0;
    logic [2:0]  ex_funct3 = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_ready, mem_we, mem_valid, mem_fault;
    logic [31:0] mem_rdata, mem_addr, mem_wd;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_ld_funct3;
    logic [1:0]  mem_ld_off;

    logic [31:0] mem [256];
    int checks = 0, failures = 0;

    assign mem_rdata = mem[mem_addr[9:2]];
    always #5 CLK = ~CLK;

    mem_access_stage #(.CHECK_ALIGN(1'b1)) dut (
        .CLK(CLK), .RST_X(RST_X), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_funct3(ex_funct3),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_rd(ex_rd),
        .flush(flush), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .mem_we(mem_we), .mem_valid(mem_valid), .mem_rd(mem_rd),
        .mem_ld_funct3(mem_ld_funct3), .mem_ld_off(mem_ld_off), .mem_fault(mem_fault)
    );

    typedef struct {
        logic v, ld, st, fl;
        logic [2:0] f3;
        logic [31:0] a, wd;
        logic [4:0] rd;
        logic ev, ewe, ef;
        logic [31:0] ea, ewd;
        logic [4:0] erd;
        logic [1:0] eoff;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd, input logic fl);
        ex_valid = v; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
        ex_addr = a; ex_wdata = wd; ex_rd = rd; flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic is_bad(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a);
        int size;
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        if (!ld && !st) return 1'b0;
        if (ld && st) return 1'b1;
        if (st && f3 > 3'd2) return 1'b1;
        if (ld && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b1;
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] merge_model(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] off, input logic half);
        int sh;
        logic [31:0] mask;
        sh   = half ? 16 * (off / 2) : 8 * off;
        mask = half ? 32'h0000_FFFF : 32'h0000_00FF;
        return (old & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    logic        r_v, r_ld, r_st, r_fl, busy, p_half, ev, ewe, ef, enter_rmw;
    logic [2:0]  r_f3;
    logic [31:0] r_a, r_wd, p_addr, ea, ewd;
    logic [4:0]  r_rd, erd;
    logic [1:0]  p_off;
    int          k;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[64] = 32'h1122_3344;

        vt.push_back('{1'b1,1'b0,1'b1,1'b0,3'b010,32'h104,32'hDEADBEEF,5'd3, 1'b1,1'b1,1'b0,32'h104,32'hDEADBEEF,5'd0,2'd0});
        vt.push_back('{1'b1,1'b1,1'b0,1'b0,3'b010,32'h106,32'h0,5'd1,       1'b0,1'b0,1'b1,32'h0,32'h0,5'd0,2'd0});
        vt.push_back('{1'b1,1'b1,1'b0,1'b0,3'b010,32'h108,32'h0,5'd7,       1'b1,1'b0,1'b0,32'h108,32'h0,5'd7,2'd0});
        vt.push_back('{1'b1,1'b0,1'b0,1'b0,3'b000,32'h7,32'h0,5'd5,         1'b1,1'b0,1'b0,32'h7,32'h0,5'd5,2'd3});
        vt.push_back('{1'b1,1'b1,1'b0,1'b0,3'b100,32'h10B,32'h0,5'd2,       1'b1,1'b0,1'b0,32'h108,32'h0,5'd2,2'd3});
        vt.push_back('{1'b1,1'b1,1'b0,1'b0,3'b001,32'h103,32'h0,5'd2,       1'b0,1'b0,1'b1,32'h0,32'h0,5'd0,2'd0});
        vt.push_back('{1'b1,1'b1,1'b0,1'b0,3'b101,32'h10A,32'h0,5'd9,       1'b1,1'b0,1'b0,32'h108,32'h0,5'd9,2'd2});
        vt.push_back('{1'b1,1'b0,1'b1,1'b0,3'b100,32'h100,32'h5,5'd0,       1'b0,1'b0,1'b1,32'h0,32'h0,5'd0,2'd0});
        vt.push_back('{1'b1,1'b1,1'b0,1'b0,3'b011,32'h100,32'h0,5'd4,       1'b0,1'b0,1'b1,32'h0,32'h0,5'd0,2'd0});
        vt.push_back('{1'b1,1'b1,1'b1,1'b0,3'b010,32'h100,32'h0,5'd4,       1'b0,1'b0,1'b1,32'h0,32'h0,5'd0,2'd0});
        vt.push_back('{1'b0,1'b1,1'b0,1'b0,3'b010,32'h100,32'h0,5'd4,       1'b0,1'b0,1'b0,32'h0,32'h0,5'd0,2'd0});
        vt.push_back('{1'b1,1'b0,1'b1,1'b1,3'b010,32'h100,32'h77,5'd0,      1'b0,1'b0,1'b0,32'h0,32'h0,5'd0,2'd0});
        vt.push_back('{1'b1,1'b1,1'b0,1'b0,3'b000,32'h101,32'h0,5'd4,       1'b1,1'b0,1'b0,32'h100,32'h0,5'd4,2'd1});
        vt.push_back('{1'b1,1'b0,1'b1,1'b0,3'b010,32'h0,32'h12345678,5'd31, 1'b1,1'b1,1'b0,32'h0,32'h12345678,5'd0,2'd0});
        vt.push_back('{1'b1,1'b0,1'b0,1'b0,3'b011,32'h13,32'h0,5'd6,        1'b1,1'b0,1'b0,32'h13,32'h0,5'd6,2'd3});

        // Reset state, then the first op in the first cycle after release
        tick();
        tick();
        chk("rst_valid", mem_valid, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_fault", mem_fault, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rd", mem_rd, 0);
        chk("rst_ready", ex_ready, 0);
        RST_X = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].v, vt[i].ld, vt[i].st, vt[i].f3, vt[i].a, vt[i].wd, vt[i].rd, vt[i].fl);
            tick();
            chk($sformatf("vec%0d_valid", i), mem_valid, vt[i].ev);
            chk($sformatf("vec%0d_we", i), mem_we, vt[i].ewe);
            chk($sformatf("vec%0d_fault", i), mem_fault, vt[i].ef);
            chk($sformatf("vec%0d_ready", i), ex_ready, 1);
            if (vt[i].ev) begin
                chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].ea);
                chk($sformatf("vec%0d_rd", i), mem_rd, vt[i].erd);
            end
            if (vt[i].ewe) chk($sformatf("vec%0d_wd", i), mem_wd, vt[i].ewd);
            if (vt[i].ev && vt[i].ld) begin
                chk($sformatf("vec%0d_off", i), mem_ld_off, vt[i].eoff);
                chk($sformatf("vec%0d_f3", i), mem_ld_funct3, vt[i].f3);
            end
        end

        // SB into 0x11223344 lane 2
        drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h102, 32'h0000_00AA, 5'd0, 1'b0);
        tick();
        chk("sb_rmw_ready", ex_ready, 0);
        chk("sb_rmw_valid", mem_valid, 0);
        chk("sb_rmw_we", mem_we, 0);
        chk("sb_rmw_addr", mem_addr, 32'h100);
        idle();
        tick();
        chk("sb_wd", mem_wd, 32'h11AA_3344);
        chk("sb_we", mem_we, 1);
        chk("sb_valid", mem_valid, 1);
        chk("sb_ready", ex_ready, 1);

        // SH into upper half
        drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h102, 32'h0000_BEEF, 5'd0, 1'b0);
        tick();
        chk("sh_rmw_ready", ex_ready, 0);
        idle();
        tick();
        chk("sh_wd", mem_wd, 32'hBEEF_3344);
        chk("sh_we", mem_we, 1);

        // Flush during the read cycle aborts the write
        drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h103, 32'h0000_0055, 5'd0, 1'b0);
        tick();
        chk("fl_rmw_ready", ex_ready, 0);
        drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b1);
        tick();
        chk("fl_we", mem_we, 0);
        chk("fl_valid", mem_valid, 0);
        chk("fl_fault", mem_fault, 0);
        chk("fl_ready", ex_ready, 1);
        idle();

        // Reset in the middle of a read-modify-write
        drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h100, 32'h0000_1234, 5'd0, 1'b0);
        tick();
        RST_X = 1'b0;
        #1;
        chk("rr_addr", mem_addr, 0);
        chk("rr_valid", mem_valid, 0);
        chk("rr_ready", ex_ready, 0);
        idle();
        tick();
        chk("rr_we", mem_we, 0);
        RST_X = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h7, 32'h0, 5'd5, 1'b0);
        tick();
        chk("rr_add_addr", mem_addr, 32'h7);
        chk("rr_add_rd", mem_rd, 5);
        chk("rr_add_valid", mem_valid, 1);
        chk("rr_add_we", mem_we, 0);
        idle();
        tick();

        // Randomized run against the behavioural model
        busy = 1'b0;
        p_addr = '0; p_off = '0; p_half = 1'b0; r_wd = '0;
        for (int i = 0; i < 600; i++) begin
            k    = $urandom_range(0, 9);
            r_v  = $urandom_range(0, 9) != 0;
            r_ld = k < 4 || k == 9;
            r_st = (k >= 4 && k < 8) || k == 9;
            r_f3 = 3'($urandom_range(0, 7));
            if (r_st && $urandom_range(0, 3) != 0) r_f3 = 3'($urandom_range(0, 2));
            r_a  = $urandom;
            if ($urandom_range(0, 1) != 0) r_a[1:0] = 2'b00;
            r_fl = $urandom_range(0, 15) == 0;
            r_rd = 5'($urandom_range(0, 31));
            chk("rnd_ready", ex_ready, !busy);
            ev = 1'b0; ewe = 1'b0; ef = 1'b0; enter_rmw = 1'b0; ea = '0; ewd = '0; erd = '0;
            if (busy) begin
                busy = 1'b0;
                if (!r_fl) begin
                    ev = 1'b1; ewe = 1'b1; ea = p_addr;
                    ewd = merge_model(mem[p_addr[9:2]], r_wd, p_off, p_half);
                end
            end else if (r_v && !r_fl) begin
                if (is_bad(r_ld, r_st, r_f3, r_a))
                    ef = 1'b1;
                else if (r_st && !r_ld && r_f3 != 3'b010) begin
                    busy = 1'b1; enter_rmw = 1'b1;
                    p_addr = r_a & ~32'h3; p_off = r_a[1:0]; p_half = r_f3 == 3'b001;
                end else begin
                    ev = 1'b1; ewe = r_st && !r_ld;
                    ea = (r_ld || r_st) ? (r_a & ~32'h3) : r_a;
                    erd = ewe ? 5'd0 : r_rd;
                    ewd = r_wd;
                end
            end
            if (!busy || enter_rmw) r_wd = enter_rmw ? $urandom : r_wd;
            if (!enter_rmw && !(ev && ewe && ea == p_addr && ewd != r_wd)) r_wd = ev && ewe ? ewd : $urandom;
            if (ev && ewe && !r_st) r_wd = r_wd;
            drive(r_v, r_ld, r_st, r_f3, r_a, enter_rmw ? r_wd : (ev && ewe && r_st ? ewd : r_wd), r_rd, r_fl);
            tick();
            chk("rnd_valid", mem_valid, ev);
            chk("rnd_we", mem_we, ewe);
            chk("rnd_fault", mem_fault, ef);
            if (ev || enter_rmw) chk("rnd_addr", mem_addr, enter_rmw ? p_addr : ea);
            if (ev) chk("rnd_rd", mem_rd, erd);
            if (ewe) chk("rnd_wd", mem_wd, ewd);
            if (ev && r_ld && !busy && !ewe && (r_v && !r_fl)) begin
                chk("rnd_off", mem_ld_off, r_a[1:0]);
                chk("rnd_f3", mem_ld_funct3, r_f3);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
